// File: rtl/seq_karatsuba_mult.sv
// Sequential one-level Karatsuba multiplier sharing one radix-4 Booth unit across three half-width products.
// Define SEQ_KARA_CLMUL_EN to build the carry-less (GF(2)[x]) product mode selected by the clmul port.
module seq_karatsuba_mult #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           clmul,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned P  = 2 * H + 2;        // shared multiplier product width
  localparam int unsigned ND = (H + 3) / 2;      // Booth digits covering H+2 zero-extended bits
  localparam int unsigned YW = 2 * ND + 1;       // recoded multiplier incl. implicit LSB zero

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_HH  = 3'd1,
    MUL_LL  = 3'd2,
    MUL_MID = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [P-1:0]     p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [2*W-1:0]   p_d;
  logic             out_valid_d;
  logic             cl_mode;

  logic [H:0]       sa, sb, mx, my;
  logic [P-1:0]     xe, pp, booth_prod, mul_prod, m_int;
  logic [YW-1:0]    yx;
  logic [2:0]       trip;
  logic [2*W-1:0]   combine_int, combine_res;

`ifdef SEQ_KARA_CLMUL_EN
  logic             clmul_q, clmul_d;
  logic [P-1:0]     cl_prod, m_cl;
  logic [2*W-1:0]   combine_cl;
  assign cl_mode = clmul_q;
`else
  logic unused_clmul;
  assign unused_clmul = clmul;
  assign cl_mode      = 1'b0;
`endif

  assign in_ready = (state == IDLE);

  // Middle operands: sums for integer mode, XORs for carry-less mode
  always_comb begin
    sa = {1'b0, a_q[W-1:H]} + {1'b0, a_q[H-1:0]};
    sb = {1'b0, b_q[W-1:H]} + {1'b0, b_q[H-1:0]};
    if (cl_mode) begin
      sa = {1'b0, a_q[W-1:H] ^ a_q[H-1:0]};
      sb = {1'b0, b_q[W-1:H] ^ b_q[H-1:0]};
    end
  end

  // Operand select for the shared multiplier
  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      MUL_HH:  begin mx = {1'b0, a_q[W-1:H]}; my = {1'b0, b_q[W-1:H]}; end
      MUL_LL:  begin mx = {1'b0, a_q[H-1:0]}; my = {1'b0, b_q[H-1:0]}; end
      MUL_MID: begin mx = sa;                 my = sb;                 end
      default: begin mx = '0;                 my = '0;                 end
    endcase
  end

  // Radix-4 Booth multiplier, accumulated modulo 2^P (exact since the product fits P bits)
  always_comb begin
    xe         = P'(mx);
    yx         = {(YW-1)'(my), 1'b0};
    booth_prod = '0;
    pp         = '0;
    trip       = '0;
    for (int i = 0; i < int'(ND); i++) begin
      trip = yx[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe << 1;
        3'b100:         pp = -(xe << 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      booth_prod = booth_prod + (pp << (2 * i));
    end
  end

`ifdef SEQ_KARA_CLMUL_EN
  // Carry-less product: shifted rows combined by XOR
  always_comb begin
    cl_prod = '0;
    for (int i = 0; i <= int'(H); i++) begin
      if (my[i]) cl_prod = cl_prod ^ (xe << i);
    end
  end
  assign mul_prod = clmul_q ? cl_prod : booth_prod;
`else
  assign mul_prod = booth_prod;
`endif

  // Recombination; the integer sum's carry out of 2W bits is always zero and is dropped
  always_comb begin
    m_int       = p3_q - p1_q - p2_q;
    combine_int = ((2*W)'(p1_q) << W) + ((2*W)'(m_int) << H) + (2*W)'(p2_q);
    combine_res = combine_int;
`ifdef SEQ_KARA_CLMUL_EN
    m_cl        = p3_q ^ p1_q ^ p2_q;
    combine_cl  = ((2*W)'(p1_q) << W) ^ ((2*W)'(m_cl) << H) ^ (2*W)'(p2_q);
    if (clmul_q) combine_res = combine_cl;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state;
    a_d         = a_q;
    b_d         = b_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    p_d         = p;
    out_valid_d = out_valid;
`ifdef SEQ_KARA_CLMUL_EN
    clmul_d     = clmul_q;
`endif
    case (state)
      IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
`ifdef SEQ_KARA_CLMUL_EN
          clmul_d = clmul;
`endif
          state_d = MUL_HH;
        end
      end
      MUL_HH:  begin p1_d = mul_prod; state_d = MUL_LL;  end
      MUL_LL:  begin p2_d = mul_prod; state_d = MUL_MID; end
      MUL_MID: begin p3_d = mul_prod; state_d = COMBINE; end
      COMBINE: begin p_d = combine_res; state_d = DONE;  end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      p         <= '0;
      out_valid <= 1'b0;
`ifdef SEQ_KARA_CLMUL_EN
      clmul_q   <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      p         <= p_d;
      out_valid <= out_valid_d;
`ifdef SEQ_KARA_CLMUL_EN
      clmul_q   <= clmul_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_karatsuba_mult.sv
// Randomised self-checking bench for seq_karatsuba_mult against a plain-arithmetic product model.
module tb_seq_karatsuba_mult;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           clmul;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  int checks = 0;
  int errors = 0;

  seq_karatsuba_mult #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clmul     (clmul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  // Reference: integer product, or polynomial product over GF(2) when that mode is built
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic cl);
    logic [63:0] r;
    logic        use_cl;
`ifdef SEQ_KARA_CLMUL_EN
    use_cl = cl;
`else
    use_cl = cl & 1'b0;
`endif
    r = '0;
    if (use_cl) begin
      for (int i = 0; i < 32; i++) if (y[i]) r = r ^ (64'(x) << i);
    end else begin
      r = 64'(x) * 64'(y);
    end
    return r;
  endfunction

  // One transaction: accept, wait for result, optional stall (optionally poking in_valid), then handshake
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcl,
                       input int stall, input bit chk_lat, input bit rand_ready, input bit poke);
    logic [63:0] want;
    int          waited;
    int          lat;
    want = ref_prod(ta, tb_v, tcl);
    @(negedge clk);
    a = ta; b = tb_v; clmul = tcl; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; clmul = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 30) begin
      if (rand_ready) out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
      return;
    end
    if (chk_lat) begin
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL latency got=%0d required=5", lat);
      end
    end
    checks++;
    if (p !== want) begin
      errors++;
      $display("FAIL product a=%h b=%h cl=%0b got=%h required=%h", ta, tb_v, tcl, p, want);
    end
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'(s & 1); a = $urandom; b = $urandom; clmul = 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if (p !== want || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold p=%h ov=%0b ir=%0b required p=%h ov=1 ir=0", p, out_valid, in_ready, want);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake ov=%0b ir=%0b required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || p !== 64'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset ov=%0b p=%h ir=%0b required ov=0 p=0 ir=1", out_valid, p, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(32'h0001_0002, 32'h0003_0004, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    do_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clmul();
    do_op(32'h0001_0001, 32'h0001_0001, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    do_op(32'h0001_0001, 32'h0001_0001, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10, 1'b0, 1'b0, 1'b1);
    do_op(32'h0BAD_F00D, 32'h0000_0007, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; clmul = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== 64'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid ov=%0b p=%h ir=%0b required ov=0 p=0 ir=1", out_valid, p, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_result ov=%0b p=%h required ov=0", out_valid, p);
      end
    end
    out_ready = 1'b0;
    do_op(32'd3, 32'd5, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'($urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'hFFFF_FFFF;
        1:       rb = {$urandom_range(0, 65535), 16'h0000} >> 16;
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    clmul     = 1'b0;
    test_reset();
    test_directed();
    test_clmul();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
